// File: rtl/router_pkt_reader.sv
// Destination-side packet reader for one router output port: pulls a packet out of the
// port FIFO, streams its payload, checks parity and address, counts delivered/dropped packets.
module router_pkt_reader #(
  parameter logic [1:0] PORT_ADDR = 2'b00
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  input  logic [4:0] rd_delay,
  output logic       read_enb,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic       pkt_done,
  output logic [5:0] pkt_len,
  output logic       parity_err,
  output logic       addr_err,
  output logic [7:0] pkt_cnt,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, WAIT, HDR_RD, HDR_CAP, PAY, LAST} state_t;

  state_t     state_q, state_d;
  logic [4:0] wait_q, wait_d;
  logic [6:0] iss_q, iss_d;
  logic [6:0] rem_q, rem_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] hdr_addr_q, hdr_addr_d;
  logic       cap_pend_q, cap_pend_d;
  logic       read_enb_q, read_enb_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_vld_q, byte_vld_d;
  logic       pkt_done_q, pkt_done_d;
  logic [5:0] pkt_len_q, pkt_len_d;
  logic       parity_err_q, parity_err_d;
  logic       addr_err_q, addr_err_d;
  logic [7:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [6:0] pkt_total;

  // Reads to issue after the header: payload plus the parity byte.
  assign pkt_total = {1'b0, pkt_len_q} + 7'd1;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    iss_d        = iss_q;
    rem_d        = rem_q;
    acc_d        = acc_q;
    hdr_addr_d   = hdr_addr_q;
    cap_pend_d   = read_enb_q;
    read_enb_d   = 1'b0;
    byte_out_d   = byte_out_q;
    byte_vld_d   = 1'b0;
    pkt_done_d   = 1'b0;
    pkt_len_d    = pkt_len_q;
    parity_err_d = parity_err_q;
    addr_err_d   = addr_err_q;
    pkt_cnt_d    = pkt_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (vld_out) begin
          wait_d  = rd_delay;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 5'd0) state_d = HDR_RD;
        else                wait_d  = wait_q - 5'd1;
      end
      HDR_RD: begin
        // Leave once the single header strobe has been presented to the FIFO.
        if (read_enb_q)   state_d    = HDR_CAP;
        else if (vld_out) read_enb_d = 1'b1;
      end
      HDR_CAP: begin
        pkt_len_d  = data_out[7:2];
        hdr_addr_d = data_out[1:0];
        acc_d      = data_out;
        rem_d      = {1'b0, data_out[7:2]} + 7'd1;
        read_enb_d = vld_out;
        iss_d      = {6'd0, vld_out};
        state_d    = PAY;
      end
      PAY: begin
        read_enb_d = vld_out && (iss_q < pkt_total);
        iss_d      = iss_q + {6'd0, read_enb_d};
        if (cap_pend_q) begin
          if (rem_q == 7'd1) begin
            read_enb_d   = 1'b0;
            pkt_done_d   = 1'b1;
            parity_err_d = (acc_q != data_out);
            addr_err_d   = (hdr_addr_q != PORT_ADDR);
            pkt_cnt_d    = pkt_cnt_q + 8'd1;
            state_d      = LAST;
          end else begin
            byte_out_d = data_out;
            byte_vld_d = 1'b1;
            acc_d      = acc_q ^ data_out;
            rem_d      = rem_q - 7'd1;
          end
        end
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An abort overrides everything, including a parity capture in the same cycle.
    if (soft_reset && (state_q != IDLE)) begin
      state_d      = IDLE;
      read_enb_d   = 1'b0;
      cap_pend_d   = 1'b0;
      byte_vld_d   = 1'b0;
      pkt_done_d   = 1'b0;
      byte_out_d   = byte_out_q;
      pkt_len_d    = pkt_len_q;
      parity_err_d = parity_err_q;
      addr_err_d   = addr_err_q;
      pkt_cnt_d    = pkt_cnt_q;
      drop_cnt_d   = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      wait_q       <= 5'd0;
      iss_q        <= 7'd0;
      rem_q        <= 7'd0;
      acc_q        <= 8'd0;
      hdr_addr_q   <= 2'd0;
      cap_pend_q   <= 1'b0;
      read_enb_q   <= 1'b0;
      byte_out_q   <= 8'd0;
      byte_vld_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_len_q    <= 6'd0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pkt_cnt_q    <= 8'd0;
      drop_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      iss_q        <= iss_d;
      rem_q        <= rem_d;
      acc_q        <= acc_d;
      hdr_addr_q   <= hdr_addr_d;
      cap_pend_q   <= cap_pend_d;
      read_enb_q   <= read_enb_d;
      byte_out_q   <= byte_out_d;
      byte_vld_q   <= byte_vld_d;
      pkt_done_q   <= pkt_done_d;
      pkt_len_q    <= pkt_len_d;
      parity_err_q <= parity_err_d;
      addr_err_q   <= addr_err_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign read_enb   = read_enb_q;
  assign byte_out   = byte_out_q;
  assign byte_vld   = byte_vld_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = pkt_len_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader: a queue stands in for the port FIFO and the
// bench plays the router's role for vld_out, data_out and soft_reset.
module tb_router_pkt_reader;

  logic       clock;
  logic       resetn;
  logic       vld_out;
  logic [7:0] data_out;
  logic       soft_reset;
  logic [4:0] rd_delay;
  logic       read_enb;
  logic [7:0] byte_out;
  logic       byte_vld;
  logic       pkt_done;
  logic [5:0] pkt_len;
  logic       parity_err;
  logic       addr_err;
  logic [7:0] pkt_cnt;
  logic [7:0] drop_cnt;

  router_pkt_reader #(.PORT_ADDR(2'b00)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .soft_reset (soft_reset),
    .rd_delay   (rd_delay),
    .read_enb   (read_enb),
    .byte_out   (byte_out),
    .byte_vld   (byte_vld),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] fifo[$];
  logic [7:0] got[$];
  logic [7:0] exp_b[$];
  logic       gap;
  int         n_vec, n_miscmp;
  int         cyc, n_rd, n_done, first_rd_cyc, last_rd_cyc, first_bv_cyc, done_cyc;
  logic       last_perr, last_aerr;

  task automatic check_val(input string tag, input int got_v, input int exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic upd_vld();
    vld_out = !gap && (fifo.size() > 0);
  endtask

  task automatic push_b(input logic [7:0] b);
    fifo.push_back(b);
    upd_vld();
  endtask

  task automatic clr_mon();
    n_rd = 0;
    got.delete();
    first_rd_cyc = -1;
    first_bv_cyc = -1;
    last_rd_cyc  = -1;
  endtask

  // Sample at the current negedge, then advance one cycle; the FIFO pops on the strobe
  // the DUT presented at the intervening rising edge.
  task automatic tick();
    logic r;
    r = read_enb;
    if (r) begin
      n_rd++;
      last_rd_cyc = cyc;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (byte_vld) begin
      got.push_back(byte_out);
      if (first_bv_cyc < 0) first_bv_cyc = cyc;
    end
    if (pkt_done) begin
      n_done++;
      done_cyc  = cyc;
      last_perr = parity_err;
      last_aerr = addr_err;
      $display("pkt %0d: len=%0d bytes=%0d perr=%0b aerr=%0b cnt=%0d",
               n_done, pkt_len, got.size(), parity_err, addr_err, pkt_cnt);
    end
    @(negedge clock);
    cyc++;
    if (r && fifo.size() > 0) data_out = fifo.pop_front();
    upd_vld();
  endtask

  task automatic run_pkt(input int max_cyc);
    int start, k;
    start = n_done;
    k = 0;
    while (n_done == start && k < max_cyc) begin
      tick();
      k++;
    end
    if (n_done == start) check_val("pkt_timeout", 0, 1);
  endtask

  task automatic check_bytes(input string tag);
    int n;
    check_val({tag, "_nbytes"}, got.size(), exp_b.size());
    n = (got.size() < exp_b.size()) ? got.size() : exp_b.size();
    for (int i = 0; i < n; i++) check_val({tag, "_byte"}, int'(got[i]), int'(exp_b[i]));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    soft_reset = 1'b0;
    gap = 1'b0;
    rd_delay = 5'd0;
    fifo.delete();
    vld_out = 1'b0;
    data_out = 8'h00;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int c0;
    n_vec = 0; n_miscmp = 0; cyc = 0; n_done = 0; done_cyc = 0;
    last_perr = 1'b0; last_aerr = 1'b0;
    clr_mon();
    do_reset();

    // Reset values
    check_val("rst_read_enb", int'(read_enb), 0);
    check_val("rst_byte_vld", int'(byte_vld), 0);
    check_val("rst_pkt_done", int'(pkt_done), 0);
    check_val("rst_pkt_len", int'(pkt_len), 0);
    check_val("rst_perr", int'(parity_err), 0);
    check_val("rst_aerr", int'(addr_err), 0);
    check_val("rst_pkt_cnt", int'(pkt_cnt), 0);
    check_val("rst_drop_cnt", int'(drop_cnt), 0);

    // Normal packet: len=3, addr=0, payload 11 22 33, parity 0x0C
    clr_mon();
    c0 = cyc;
    push_b(8'h0C); push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h0C);
    run_pkt(60);
    exp_b = '{8'h11, 8'h22, 8'h33};
    check_bytes("t1");
    check_val("t1_reads", n_rd, 5);
    check_val("t1_first_rd", first_rd_cyc - c0, 3);
    check_val("t1_first_bv", first_bv_cyc - c0, 7);
    check_val("t1_done_lag", done_cyc - last_rd_cyc, 2);
    check_val("t1_perr", int'(last_perr), 0);
    check_val("t1_aerr", int'(last_aerr), 0);
    check_val("t1_pkt_len", int'(pkt_len), 3);
    check_val("t1_pkt_cnt", int'(pkt_cnt), 1);

    // Bad parity and address: header 0x0A, payload 5A C3, parity 0x93^0x01
    clr_mon();
    push_b(8'h0A); push_b(8'h5A); push_b(8'hC3); push_b(8'h92);
    run_pkt(60);
    exp_b = '{8'h5A, 8'hC3};
    check_bytes("t2");
    check_val("t2_perr", int'(last_perr), 1);
    check_val("t2_aerr", int'(last_aerr), 1);
    check_val("t2_pkt_cnt", int'(pkt_cnt), 2);

    // Zero-length packet followed back-to-back by len=1 (payload 7E, parity 7A)
    do_reset();
    rd_delay = 5'd1;
    clr_mon();
    push_b(8'h00); push_b(8'h00);
    push_b(8'h04); push_b(8'h7E); push_b(8'h7A);
    run_pkt(60);
    check_val("t3a_reads", n_rd, 2);
    check_val("t3a_nbytes", got.size(), 0);
    check_val("t3a_perr", int'(last_perr), 0);
    clr_mon();
    c0 = done_cyc;
    run_pkt(60);
    check_val("t3b_hdr_gap", first_rd_cyc - c0, 5);
    check_val("t3b_reads", n_rd, 3);
    exp_b = '{8'h7E};
    check_bytes("t3b");
    check_val("t3b_perr", int'(last_perr), 0);
    check_val("t3_pkt_cnt", int'(pkt_cnt), 2);

    // Underflow stall mid-payload: len=8, payload 01..08, parity 0x28
    rd_delay = 5'd0;
    clr_mon();
    push_b(8'h20);
    for (int i = 1; i <= 8; i++) push_b(i[7:0]);
    push_b(8'h28);
    begin
      int k;
      k = 0;
      while (got.size() < 3 && k < 60) begin
        tick();
        k++;
      end
      check_val("t4_reach_gap", got.size() >= 3 ? 1 : 0, 1);
    end
    gap = 1'b1;
    vld_out = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val("t4_gap_rd", int'(read_enb), 0);
      tick();
    end
    gap = 1'b0;
    upd_vld();
    run_pkt(60);
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check_bytes("t4");
    check_val("t4_reads", n_rd, 10);
    check_val("t4_perr", int'(last_perr), 0);

    // Timeout abort: rd_delay=31, router flushes after 30 unread cycles
    rd_delay = 5'd31;
    clr_mon();
    begin
      int d0;
      d0 = n_done;
      push_b(8'h04); push_b(8'h7E); push_b(8'h7A);
      for (int i = 0; i < 30; i++) tick();
      soft_reset = 1'b1;
      fifo.delete();
      upd_vld();
      tick();
      soft_reset = 1'b0;
      tick();
      tick();
      check_val("t5_no_reads", n_rd, 0);
      check_val("t5_no_done", n_done - d0, 0);
      check_val("t5_drop_cnt", int'(drop_cnt), 1);
    end
    rd_delay = 5'd0;
    clr_mon();
    c0 = cyc;
    push_b(8'h04); push_b(8'h55); push_b(8'h51);
    run_pkt(60);
    check_val("t5_first_rd", first_rd_cyc - c0, 3);
    exp_b = '{8'h55};
    check_bytes("t5");
    check_val("t5_perr", int'(last_perr), 0);
    check_val("t5_pkt_cnt", int'(pkt_cnt), 4);
    tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    tick();
    check_val("t5_idle_srst", int'(drop_cnt), 1);

    // Asynchronous reset in the middle of the header read
    clr_mon();
    push_b(8'h0C); push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h0C);
    begin
      int k;
      k = 0;
      while (!read_enb && k < 20) begin
        tick();
        k++;
      end
    end
    check_val("t6_rd_before_rst", int'(read_enb), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_val("t6_async_rd", int'(read_enb), 0);
    check_val("t6_async_cnt", int'(pkt_cnt), 0);
    check_val("t6_async_drop", int'(drop_cnt), 0);
    do_reset();

    // Counter wrap: 256 zero-length packets
    for (int i = 0; i < 256; i++) begin
      push_b(8'h00);
      push_b(8'h00);
    end
    for (int i = 0; i < 256; i++) begin
      clr_mon();
      run_pkt(40);
      if (i == 254) check_val("t7_cnt_255", int'(pkt_cnt), 255);
    end
    check_val("t7_cnt_wrap", int'(pkt_cnt), 0);

    // Drop saturation: 260 aborts while waiting
    rd_delay = 5'd5;
    for (int i = 0; i < 260; i++) begin
      push_b(8'h04);
      tick();
      soft_reset = 1'b1;
      fifo.delete();
      upd_vld();
      tick();
      soft_reset = 1'b0;
      tick();
      if (i == 254) check_val("t8_drop_255", int'(drop_cnt), 255);
    end
    check_val("t8_drop_sat", int'(drop_cnt), 255);
    check_val("t8_pkt_cnt", int'(pkt_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
